// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map and the speculative-write packet used by the CSR regfile.
package csr_regfile_pkg;

  localparam int CSR_WIDTH     = 64;
  localparam int CSR_WIDTH_LOG = 12;

  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FFLAGS   = 12'h001;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FRM      = 12'h002;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FCSR     = 12'h003;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_TIME     = 12'hC01;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_INSTRET  = 12'hC02;

  typedef struct packed {
    logic                     valid;
    logic [CSR_WIDTH_LOG-1:0] addr;
    logic [CSR_WIDTH-1:0]     data;
  } csrPendPkt;

endpackage

// File: rtl/csr_pending_slot.sv
// Single-entry holding register for a speculative CSR write; released on commit, dropped on flush.
module csr_pending_slot
  import csr_regfile_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [CSR_WIDTH_LOG-1:0] wr_addr_i,
  input  logic [CSR_WIDTH-1:0]     wr_data_i,
  input  logic                     commit_i,
  input  logic                     flush_i,
  output logic                     ready_o,
  output logic                     apply_o,
  output csrPendPkt                pend_o
);

  csrPendPkt pend_q;
  csrPendPkt pend_d;
  logic      capture;

  assign ready_o = ~pend_q.valid | commit_i;
  assign capture = wr_en_i & ready_o & ~flush_i;
  assign apply_o = commit_i & pend_q.valid;
  assign pend_o  = pend_q;

  // A commit coinciding with a flush still retires; the flush only empties the slot afterwards.
  always_comb begin
    pend_d = pend_q;
    if (apply_o || flush_i) begin
      pend_d.valid = 1'b0;
    end
    if (capture) begin
      pend_d.valid = 1'b1;
      pend_d.addr  = wr_addr_i;
      pend_d.data  = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// Architectural CSR storage: retire-time write application, counters, FP flag accrual and registered reads.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int COMMIT_WIDTH = 4,
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csrWrEn_i,
  input  logic [CSR_WIDTH_LOG-1:0] csrWrAddr_i,
  input  logic [CSR_WIDTH-1:0]     csrWrData_i,
  output logic                     csrWrReady_o,
  input  logic                     commitCsr_i,
  input  logic                     flush_i,
  input  logic [CNT_W-1:0]         commitCount_i,
  input  logic                     fpFlagsValid_i,
  input  logic [4:0]               fpFlags_i,
  input  logic                     csrRdEn_i,
  input  logic [CSR_WIDTH_LOG-1:0] csrRdAddr_i,
  output logic [CSR_WIDTH-1:0]     csrRdData_o,
  output logic                     csrRdValid_o,
  output logic                     csrRdIllegal_o,
  output logic [2:0]               frm_o,
  output logic                     csrPending_o
);

  csrPendPkt pend;
  logic      pend_apply;

  logic [4:0]           fflags_q,   fflags_d;
  logic [2:0]           frm_q,      frm_d;
  logic [CSR_WIDTH-1:0] mscratch_q, mscratch_d;
  logic [CSR_WIDTH-1:0] mepc_q,     mepc_d;
  logic [CSR_WIDTH-1:0] mcycle_q,   mcycle_d;
  logic [CSR_WIDTH-1:0] minstret_q, minstret_d;
  logic [CSR_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_illegal_q, rd_illegal_d;

  csr_pending_slot u_pending_slot (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (csrWrEn_i),
    .wr_addr_i (csrWrAddr_i),
    .wr_data_i (csrWrData_i),
    .commit_i  (commitCsr_i),
    .flush_i   (flush_i),
    .ready_o   (csrWrReady_o),
    .apply_o   (pend_apply),
    .pend_o    (pend)
  );

  // Committed writes override the free-running counter updates; FP flags accrue on top of any write.
  always_comb begin
    fflags_d   = fflags_q;
    frm_d      = frm_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + CSR_WIDTH'(commitCount_i);
    if (pend_apply) begin
      case (pend.addr)
        CSR_FFLAGS:   fflags_d   = pend.data[4:0];
        CSR_FRM:      frm_d      = pend.data[2:0];
        CSR_FCSR: begin
          frm_d    = pend.data[7:5];
          fflags_d = pend.data[4:0];
        end
        CSR_MSCRATCH: mscratch_d = pend.data;
        CSR_MEPC:     mepc_d     = {pend.data[CSR_WIDTH-1:1], 1'b0};
        CSR_MCYCLE:   mcycle_d   = pend.data;
        CSR_MINSTRET: minstret_d = pend.data;
        default: ;
      endcase
    end
    if (fpFlagsValid_i) begin
      fflags_d = fflags_d | fpFlags_i;
    end
  end

  // Reads see the pre-commit architectural state; the pending write is never forwarded.
  always_comb begin
    rd_data_d    = '0;
    rd_illegal_d = 1'b0;
    rd_valid_d   = csrRdEn_i;
    if (csrRdEn_i) begin
      case (csrRdAddr_i)
        CSR_FFLAGS:                  rd_data_d = {59'd0, fflags_q};
        CSR_FRM:                     rd_data_d = {61'd0, frm_q};
        CSR_FCSR:                    rd_data_d = {56'd0, frm_q, fflags_q};
        CSR_MSCRATCH:                rd_data_d = mscratch_q;
        CSR_MEPC:                    rd_data_d = mepc_q;
        CSR_MCYCLE, CSR_CYCLE, CSR_TIME: rd_data_d = mcycle_q;
        CSR_MINSTRET, CSR_INSTRET:   rd_data_d = minstret_q;
        default:                     rd_illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fflags_q     <= '0;
      frm_q        <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_illegal_q <= 1'b0;
    end else begin
      fflags_q     <= fflags_d;
      frm_q        <= frm_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_illegal_q <= rd_illegal_d;
    end
  end

  assign csrRdData_o    = rd_data_q;
  assign csrRdValid_o   = rd_valid_q;
  assign csrRdIllegal_o = rd_illegal_q;
  assign frm_o          = frm_q;
  assign csrPending_o   = pend.valid;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed corner sequences, a write/read table and random traffic vs a model.
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  localparam int CW    = 4;
  localparam int CNT_W = $clog2(CW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              wr_en;
  logic [11:0]       wr_addr;
  logic [63:0]       wr_data;
  logic              wr_ready;
  logic              commit;
  logic              flush;
  logic [CNT_W-1:0]  count;
  logic              fpv;
  logic [4:0]        flags;
  logic              rd_en;
  logic [11:0]       rd_addr;
  logic [63:0]       rd_data;
  logic              rd_valid;
  logic              rd_ill;
  logic [2:0]        frm;
  logic              pending;

  csr_regfile #(.COMMIT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .csrWrEn_i      (wr_en),
    .csrWrAddr_i    (wr_addr),
    .csrWrData_i    (wr_data),
    .csrWrReady_o   (wr_ready),
    .commitCsr_i    (commit),
    .flush_i        (flush),
    .commitCount_i  (count),
    .fpFlagsValid_i (fpv),
    .fpFlags_i      (flags),
    .csrRdEn_i      (rd_en),
    .csrRdAddr_i    (rd_addr),
    .csrRdData_o    (rd_data),
    .csrRdValid_o   (rd_valid),
    .csrRdIllegal_o (rd_ill),
    .frm_o          (frm),
    .csrPending_o   (pending)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural storage keyed by address, plus the held write.
  logic [63:0] arch [logic [11:0]];
  bit          m_pv;
  logic [11:0] m_pa;
  logic [63:0] m_pd;
  logic [63:0] e_rd_data;
  bit          e_rd_valid;
  bit          e_rd_ill;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [11:0] raddr;
    logic [63:0] exp_data;
    bit          exp_ill;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit m_legal(input logic [11:0] a);
    return arch.exists(a) || a == CSR_FCSR || a == CSR_CYCLE || a == CSR_TIME || a == CSR_INSTRET;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    logic [63:0] v;
    logic [63:0] fr;
    logic [63:0] ff;
    v = '0;
    if (a == CSR_FCSR) begin
      fr = arch[CSR_FRM];
      ff = arch[CSR_FFLAGS];
      v  = (fr << 5) | ff;
    end else if (a == CSR_CYCLE || a == CSR_TIME) begin
      v = arch[CSR_MCYCLE];
    end else if (a == CSR_INSTRET) begin
      v = arch[CSR_MINSTRET];
    end else if (arch.exists(a)) begin
      v = arch[a];
    end
    return v;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [63:0] d);
    if (a == CSR_FFLAGS)        arch[CSR_FFLAGS] = d % 32;
    else if (a == CSR_FRM)      arch[CSR_FRM] = d % 8;
    else if (a == CSR_FCSR) begin
      arch[CSR_FFLAGS] = d % 32;
      arch[CSR_FRM]    = (d / 32) % 8;
    end
    else if (a == CSR_MEPC)     arch[CSR_MEPC] = d - (d % 2);
    else if (a == CSR_MSCRATCH || a == CSR_MCYCLE || a == CSR_MINSTRET) arch[a] = d;
  endtask

  task automatic m_reset();
    arch.delete();
    arch[CSR_FFLAGS]   = '0;
    arch[CSR_FRM]      = '0;
    arch[CSR_MSCRATCH] = '0;
    arch[CSR_MEPC]     = '0;
    arch[CSR_MCYCLE]   = '0;
    arch[CSR_MINSTRET] = '0;
    m_pv = 1'b0;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0; flush = 0;
    count = '0; fpv = 0; flags = '0; rd_en = 0; rd_addr = '0;
  endtask

  task automatic model_step();
    bit ready;
    bit cap;
    bit app;
    e_rd_valid = rd_en;
    e_rd_ill   = rd_en && !m_legal(rd_addr);
    e_rd_data  = (rd_en && m_legal(rd_addr)) ? m_read(rd_addr) : 64'd0;
    ready = !m_pv || commit;
    chk("wr_ready", {63'd0, wr_ready}, {63'd0, ready});
    cap = wr_en && ready && !flush;
    app = commit && m_pv;
    arch[CSR_MCYCLE]   = arch[CSR_MCYCLE] + 64'd1;
    arch[CSR_MINSTRET] = arch[CSR_MINSTRET] + 64'(count);
    if (app) m_write(m_pa, m_pd);
    if (fpv) arch[CSR_FFLAGS] = arch[CSR_FFLAGS] | 64'(flags);
    if (app || flush) m_pv = 1'b0;
    if (cap) begin
      m_pv = 1'b1;
      m_pa = wr_addr;
      m_pd = wr_data;
    end
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    #1;
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, e_rd_valid});
    chk("rd_data", rd_data, e_rd_data);
    chk("rd_illegal", {63'd0, rd_ill}, {63'd0, e_rd_ill});
    chk("frm_o", {61'd0, frm}, arch[CSR_FRM]);
    chk("pending", {63'd0, pending}, {63'd0, m_pv});
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    #1;
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_illegal", {63'd0, rd_ill}, 64'd0);
    chk("rst_frm", {61'd0, frm}, 64'd0);
    chk("rst_pending", {63'd0, pending}, 64'd0);
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [11:0] a);
    rd_en = 1; rd_addr = a;
  endtask

  logic [11:0] addr_pool [12];

  initial begin
    vecs[0]  = '{CSR_FCSR,     64'hE5,                  CSR_FRM,      64'h7,                  0};
    vecs[1]  = '{CSR_FCSR,     64'hE5,                  CSR_FFLAGS,   64'h5,                  0};
    vecs[2]  = '{CSR_FRM,      64'h1FA,                 CSR_FCSR,     64'h45,                 0};
    vecs[3]  = '{CSR_FFLAGS,   64'h23,                  CSR_FCSR,     64'h43,                 0};
    vecs[4]  = '{CSR_MSCRATCH, 64'hDEAD,                CSR_MSCRATCH, 64'hDEAD,               0};
    vecs[5]  = '{CSR_MEPC,     64'h1235,                CSR_MEPC,     64'h1234,               0};
    vecs[6]  = '{CSR_CYCLE,    64'h55,                  CSR_MSCRATCH, 64'hDEAD,               0};
    vecs[7]  = '{CSR_INSTRET,  64'h55,                  CSR_MEPC,     64'h1234,               0};
    vecs[8]  = '{12'h7C0,      64'h99,                  12'h7C0,      64'h0,                  1};
    vecs[9]  = '{CSR_MSCRATCH, 64'hFFFF_0000_1234_5678, CSR_MSCRATCH, 64'hFFFF_0000_1234_5678, 0};
    vecs[10] = '{CSR_FCSR,     64'hFFFF,                CSR_FCSR,     64'hFF,                 0};
    vecs[11] = '{CSR_MEPC,     64'hFFFF_FFFF_FFFF_FFFF, CSR_MEPC,     64'hFFFF_FFFF_FFFF_FFFE, 0};

    addr_pool = '{CSR_FFLAGS, CSR_FRM, CSR_FCSR, CSR_MSCRATCH, CSR_MEPC, CSR_MCYCLE,
                  CSR_MINSTRET, CSR_CYCLE, CSR_TIME, CSR_INSTRET, 12'h7C0, 12'h004};

    do_reset();

    rd(CSR_FRM); tick();
    chk("first_rd_frm", rd_data, 64'd0);
    chk("first_rd_valid", {63'd0, rd_valid}, 64'd1);

    wr(CSR_FCSR, 64'hE5); tick();
    chk("fcsr_pending", {63'd0, pending}, 64'd1);
    tick(); tick();
    commit = 1; rd(CSR_FRM); tick();
    chk("rd_in_commit_cycle", rd_data, 64'd0);
    chk("frm_after_commit", {61'd0, frm}, 64'd7);
    rd(CSR_FRM); tick();
    chk("rd_frm_7", rd_data, 64'd7);
    rd(CSR_FFLAGS); tick();
    chk("rd_fflags_5", rd_data, 64'd5);

    wr(CSR_MSCRATCH, 64'hDEAD); tick();
    flush = 1; tick();
    chk("flush_pending", {63'd0, pending}, 64'd0);
    tick();
    rd(CSR_MSCRATCH); tick();
    chk("flushed_mscratch", rd_data, 64'd0);

    wr(CSR_MSCRATCH, 64'h11); tick();
    wr(CSR_MSCRATCH, 64'h22); #1;
    chk("ready_blocked", {63'd0, wr_ready}, 64'd0);
    tick();
    wr(CSR_MSCRATCH, 64'h33); commit = 1; #1;
    chk("ready_with_commit", {63'd0, wr_ready}, 64'd1);
    tick();
    rd(CSR_MSCRATCH); tick();
    chk("first_write_applied", rd_data, 64'h11);
    commit = 1; tick();
    rd(CSR_MSCRATCH); tick();
    chk("second_write_applied", rd_data, 64'h33);

    wr(CSR_MINSTRET, 64'd100); tick();
    repeat (4) begin count = 3; tick(); end
    count = 2; commit = 1; tick();
    rd(CSR_INSTRET); tick();
    chk("instret_100", rd_data, 64'd100);

    wr(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF); tick();
    commit = 1; tick();
    rd(CSR_MCYCLE); tick();
    chk("mcycle_max", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(CSR_MCYCLE); tick();
    chk("mcycle_wrap", rd_data, 64'd0);
    rd(CSR_CYCLE); tick();
    chk("cycle_after_wrap", rd_data, 64'd1);

    wr(CSR_FFLAGS, 64'h01); tick();
    commit = 1; tick();
    wr(CSR_FFLAGS, 64'h04); tick();
    commit = 1; fpv = 1; flags = 5'h10; tick();
    rd(CSR_FFLAGS); tick();
    chk("fflags_accrue", rd_data, 64'h14);
    rd(12'h7C0); tick();
    chk("illegal_data", rd_data, 64'd0);
    chk("illegal_flag", {63'd0, rd_ill}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].addr, vecs[i].wdata); tick();
      commit = 1; tick();
      rd(vecs[i].raddr); tick();
      chk($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_illegal", i), {63'd0, rd_ill}, {63'd0, vecs[i].exp_ill});
    end

    for (int i = 0; i < 2000; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = addr_pool[$urandom_range(0, 11)];
      wr_data = {$urandom, $urandom};
      commit  = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      count   = CNT_W'($urandom_range(0, CW));
      fpv     = ($urandom_range(0, 3) == 0);
      flags   = 5'($urandom);
      rd_en   = ($urandom_range(0, 1) == 1);
      rd_addr = addr_pool[$urandom_range(0, 11)];
      tick();
    end

    wr(CSR_MSCRATCH, 64'h77); tick();
    do_reset();
    rd(CSR_CYCLE); tick();
    chk("cycle_after_reset", rd_data, 64'd0);
    rd(CSR_MSCRATCH); commit = 1; tick();
    chk("mscratch_after_reset", rd_data, 64'd0);
    rd(CSR_MSCRATCH); tick();
    chk("lost_pending_write", rd_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
